// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// state encoding, default width and the Booth pair codes.
package booth_pkg;

  localparam int N_DEF = 4;

  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EVAL   = 3'd2,
    ADDSUB = 3'd3,
    SHIFT  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// Booth iteration counter: cleared on load, bumped once per shift,
// flags the final iteration.
module booth_iter_counter #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/booth_control.sv
// Radix-2 Booth multiplier control unit: sequences load, add/sub and
// arithmetic shift of the A/Q datapath over N iterations.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | load Q with multiplier, clear A
// EVAL   | inspect {q0,q_m1}, choose add/sub or straight shift
// ADDSUB | A <= A +/- M
// SHIFT  | arithmetic right shift of {A,Q}, advance iteration
// DONE   | product valid on {A,Q} for one cycle
module booth_control
  import booth_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic carga_q,
  output logic desp_q,
  output logic carga_a,
  output logic desp_a,
  output logic sel_a,
  output logic resta,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(N + 1);

  state_t state, state_nxt;
  logic   q_m1;
  logic   resta_r;
  logic   last;

  booth_iter_counter #(.N(N), .CW(CW)) u_iter (
    .clk   (clk),
    .reset (reset),
    .clear (state == LOAD),
    .inc   (state == SHIFT),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q_m1    <= 1'b0;
      resta_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        q_m1 <= 1'b0;
      end else if (state == SHIFT) begin
        q_m1 <= q0;
      end
      if (state == EVAL) begin
        if ({q0, q_m1} == PAIR_SUB) begin
          resta_r <= 1'b1;
        end else if ({q0, q_m1} == PAIR_ADD) begin
          resta_r <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    carga_q   = 1'b0;
    desp_q    = 1'b0;
    carga_a   = 1'b0;
    desp_a    = 1'b0;
    sel_a     = 1'b0;
    resta     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        carga_q   = 1'b1;
        carga_a   = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        // 00 and 11 pairs skip the adder entirely
        if (({q0, q_m1} == PAIR_SUB) || ({q0, q_m1} == PAIR_ADD)) begin
          state_nxt = ADDSUB;
        end else begin
          state_nxt = SHIFT;
        end
      end
      ADDSUB: begin
        carga_a   = 1'b1;
        sel_a     = 1'b1;
        resta     = resta_r;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        desp_a    = 1'b1;
        desp_q    = 1'b1;
        state_nxt = last ? DONE : EVAL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_control.sv
// Directed bench for booth_control wired to a behavioural A/Q/M datapath.
module tb_booth_control;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic q0;
  logic carga_q, desp_q, carga_a, desp_a, sel_a, resta, busy, done;

  logic [5:0] mm;
  logic [3:0] mq;
  logic [5:0] a_r = '0;
  logic [3:0] q_r = '0;

  int vectors = 0;
  int fails   = 0;

  booth_control dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q0      (q0),
    .carga_q (carga_q),
    .desp_q  (desp_q),
    .carga_a (carga_a),
    .desp_a  (desp_a),
    .sel_a   (sel_a),
    .resta   (resta),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  assign q0 = q_r[0];

  always @(posedge clk) begin
    if (carga_q) q_r <= mq;
    if (carga_a) a_r <= sel_a ? (resta ? a_r - mm : a_r + mm) : 6'd0;
    if (desp_a)  a_r <= {a_r[5], a_r[5:1]};
    if (desp_q)  q_r <= {a_r[0], q_r[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {carga_q, desp_q, carga_a, desp_a, sel_a, resta, busy, done};
  endfunction

  task automatic run(input logic [5:0] m, input logic [3:0] qv, input int exp_cyc,
                     input logic [9:0] exp_p, input int pulse_at, input string tag);
    int cyc;
    int dones;
    mm = m;
    mq = qv;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    check({tag, "_load"}, {carga_q, carga_a, sel_a, busy}, 4'b1101);
    while (!done && cyc < 40) begin
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
      check({tag, "_excl"}, (carga_q | carga_a) & (desp_q | desp_a), 0);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_product"}, {a_r, q_r}, exp_p);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, "_extra_done"}, dones, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  logic dn [0:40];
  logic bs [0:40];
  logic cq [0:40];
  int   ndone;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mm    = '0;
    mq    = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), 8'h00);

    // scenario 1: reset asserted during the first SHIFT of a run
    mm = 6'd3; mq = 4'b0110;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_shift", {desp_a, desp_q}, 2'b11);
    #2 reset = 1'b0;
    #1 check("rst_async_outs", outs(), 8'h00);
    @(negedge clk);
    check("rst_held_outs", outs(), 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {busy, done}, 2'b00);
    run(6'd3, 4'b0110, 12, 10'h012, 0, "rst_rerun");

    run(6'd3, 4'b0110, 12, 10'h012, 0, "m3_q6");
    run(6'd3, 4'b1110, 11, 10'h3FA, 0, "m3_qm2");
    run(6'd5, 4'b1000, 11, 10'h3D8, 0, "m5_qm8");
    run(6'd3, 4'b0110, 12, 10'h012, 2, "start_in_eval");

    // scenario 6: start held high, back-to-back runs with Q=0
    mm = 6'd3; mq = 4'b0000;
    @(negedge clk); start = 1'b1;
    dn[0] = 1'b0; bs[0] = 1'b0; cq[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      dn[c] = done;
      bs[c] = busy;
      cq[c] = carga_q;
      if (c == 30) start = 1'b0;
    end
    ndone = 0;
    for (int c = 1; c <= 40; c++) if (dn[c]) ndone++;
    check("held_done_count", ndone, 3);
    check("held_done1", dn[10], 1);
    check("held_gap1", bs[11], 0);
    check("held_load2", cq[12], 1);
    check("held_done2", dn[21], 1);
    check("held_gap2", bs[22], 0);
    check("held_load3", cq[23], 1);
    check("held_done3", dn[32], 1);
    check("held_product", {a_r, q_r}, 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
